// File: rtl/mem_ctrl_if.sv
// Byte-wide memory bus plus the fetch and load/store client handshakes of mem_ctrl.
// The master modport is the controller's view; slave is the CPU/RAM side.
interface mem_ctrl_if;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;

    logic        ls_req_in;
    logic        ls_we_in;
    logic [1:0]  ls_size_in;
    logic [31:0] ls_addr_in;
    logic [31:0] ls_wdata_in;
    logic [31:0] ls_rdata_out;
    logic        ls_done_out;

    modport master (
        input  mem_din, io_buffer_full,
        input  if_req_in, if_addr_in,
        input  ls_req_in, ls_we_in, ls_size_in, ls_addr_in, ls_wdata_in,
        output mem_dout, mem_a, mem_wr,
        output if_done_out, if_data_out,
        output ls_rdata_out, ls_done_out
    );

    modport slave (
        output mem_din, io_buffer_full,
        output if_req_in, if_addr_in,
        output ls_req_in, ls_we_in, ls_size_in, ls_addr_in, ls_wdata_in,
        input  mem_dout, mem_a, mem_wr,
        input  if_done_out, if_data_out,
        input  ls_rdata_out, ls_done_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory bus initiator: splits fetch and load/store word accesses into single-byte
// bus cycles, with pause rewind and IO write back-pressure.
//  state | meaning
//  IDLE  | bus parked at 0, arbitrating (load/store first)
//  READ  | issuing byte addresses and capturing returned bytes one cycle later
//  WRITE | writing one byte per cycle, holding while the IO buffer is full
//  DONE  | done pulse for the finished client, no request sampling
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      clear_in,
    output logic      busy_out,
    mem_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        fetch_q, fetch_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  issue_q, issue_d;
    logic [2:0]  cap_q, cap_d;
    logic        rd_vld_q, rd_vld_d;
    logic        paused_q, paused_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        resume;
    logic [2:0]  eff_idx;
    logic [31:0] cur_a;
    logic        io_gate;

    // After a pause the byte in flight is untrustworthy: restart from the oldest uncaptured one.
    assign resume  = paused_q && (state_q == READ);
    assign eff_idx = resume ? cap_q : issue_q;
    assign cur_a   = addr_q + {29'd0, eff_idx};
    assign io_gate = bus.io_buffer_full && (cur_a[17:16] == IO_HI);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            nbytes_q   <= '0;
            fetch_q    <= 1'b0;
            wdata_q    <= '0;
            data_q     <= '0;
            issue_q    <= '0;
            cap_q      <= '0;
            rd_vld_q   <= 1'b0;
            paused_q   <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nbytes_q   <= nbytes_d;
            fetch_q    <= fetch_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            issue_q    <= issue_d;
            cap_q      <= cap_d;
            rd_vld_q   <= rd_vld_d;
            paused_q   <= paused_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nbytes_d   = nbytes_q;
        fetch_d    = fetch_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        issue_d    = issue_q;
        cap_d      = cap_q;
        rd_vld_d   = rd_vld_q;
        paused_d   = ~rdy_in;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    data_d   = '0;
                    issue_d  = '0;
                    cap_d    = '0;
                    rd_vld_d = 1'b0;
                    if (bus.ls_req_in) begin
                        addr_d   = bus.ls_addr_in;
                        wdata_d  = bus.ls_wdata_in;
                        fetch_d  = 1'b0;
                        nbytes_d = (bus.ls_size_in == 2'd0) ? 3'd1 :
                                   (bus.ls_size_in == 2'd1) ? 3'd2 : 3'd4;
                        state_d  = bus.ls_we_in ? WRITE : READ;
                    end else if (bus.if_req_in && !clear_in) begin
                        addr_d   = bus.if_addr_in;
                        fetch_d  = 1'b1;
                        nbytes_d = 3'd4;
                        state_d  = READ;
                    end
                end
                READ: begin
                    if (fetch_q && clear_in) begin
                        state_d = IDLE;
                    end else begin
                        if (rd_vld_q && !resume) begin
                            data_d[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din;
                            cap_d = cap_q + 3'd1;
                            if (cap_d == nbytes_q) begin
                                state_d = DONE;
                                if (fetch_q) if_data_d  = data_d;
                                else         ls_rdata_d = data_d;
                            end
                        end
                        rd_vld_d = (eff_idx < nbytes_q);
                        if (eff_idx < nbytes_q) issue_d = eff_idx + 3'd1;
                    end
                end
                WRITE: begin
                    if (!io_gate) begin
                        issue_d = issue_q + 3'd1;
                        if (issue_d == nbytes_q) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_a        = '0;
        bus.mem_wr       = 1'b0;
        bus.mem_dout     = '0;
        bus.if_done_out  = 1'b0;
        bus.ls_done_out  = 1'b0;
        bus.if_data_out  = if_data_q;
        bus.ls_rdata_out = ls_rdata_q;
        busy_out         = (state_q != IDLE);
        case (state_q)
            READ: begin
                // Park at 0 once every byte is issued so no IO address is re-read.
                if (eff_idx < nbytes_q) bus.mem_a = cur_a;
            end
            WRITE: begin
                bus.mem_a    = cur_a;
                bus.mem_wr   = ~io_gate;
                bus.mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
            end
            DONE: begin
                bus.if_done_out = fetch_q;
                bus.ls_done_out = ~fetch_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized and directed bench for mem_ctrl against a byte-array memory model;
// results are predicted as whole words from that model.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clear_in, busy_out;

    mem_ctrl_if bus ();

    mem_ctrl #(.IO_HI(2'b11)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .busy_out (busy_out),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] preset    [bit [31:0]];
    logic [7:0] ram       [bit [31:0]];
    logic [7:0] model_mem [bit [31:0]];
    int         io_wr_cnt = 0;
    logic [7:0] io_last   = 8'h00;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5a;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a))    return ram[a];
        if (preset.exists(a)) return preset[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        if (preset.exists(a))    return preset[a];
        return init_byte(a);
    endfunction

    // Synchronous RAM/IO responder; a paused bus returns junk.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (bus.mem_wr) begin
                ram[bus.mem_a] = bus.mem_dout;
                if (bus.mem_a[17:16] == 2'b11) begin
                    io_wr_cnt = io_wr_cnt + 1;
                    io_last   = bus.mem_dout;
                end
            end
            bus.mem_din <= ram_rd(bus.mem_a);
        end else begin
            bus.mem_din <= 8'($urandom);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = model_rd(addr + 32'(i));
        return w;
    endfunction

    task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) model_mem[addr + 32'(i)] = wd[8*i +: 8];
    endtask

    // Per-transaction stimulus windows, as offsets from the request cycle.
    int pause_lo = -1, pause_hi = -1, iof_lo = -1, iof_hi = -1, clr_at = -1;
    logic [31:0] a_log [$];
    logic        wr_log [$];
    logic [7:0]  d_log [$];

    task automatic do_txn(input bit fetch, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat, output bit got_done);
        bit seen_busy = 0;
        a_log.delete(); wr_log.delete(); d_log.delete();
        got_done = 0; lat = -1; rdata = '0;
        @(negedge clk_in);
        if (fetch) begin
            bus.if_req_in = 1'b1; bus.if_addr_in = addr;
        end else begin
            bus.ls_req_in = 1'b1; bus.ls_we_in = we; bus.ls_size_in = size;
            bus.ls_addr_in = addr; bus.ls_wdata_in = wdata;
        end
        rdy_in = 1'b1; clear_in = 1'b0; bus.io_buffer_full = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk_in);
            rdy_in             = !(j >= pause_lo && j <= pause_hi);
            bus.io_buffer_full = (j >= iof_lo && j <= iof_hi);
            clear_in           = (j == clr_at);
            #1;
            a_log.push_back(bus.mem_a);
            wr_log.push_back(bus.mem_wr);
            d_log.push_back(bus.mem_dout);
            if (busy_out) seen_busy = 1;
            if (fetch ? bus.if_done_out : bus.ls_done_out) begin
                got_done = 1; lat = j;
                rdata = fetch ? bus.if_data_out : bus.ls_rdata_out;
                break;
            end
            if (seen_busy && !busy_out) break;
        end
        bus.if_req_in = 1'b0; bus.ls_req_in = 1'b0;
        rdy_in = 1'b1; clear_in = 1'b0; bus.io_buffer_full = 1'b0;
        pause_lo = -1; pause_hi = -1; iof_lo = -1; iof_hi = -1; clr_at = -1;
    endtask

    initial begin
        logic [31:0] rd, addr, wd;
        logic [1:0]  size;
        int lat, n, wr_cnt, io0, d_cyc, b_cyc, f_cyc;
        bit done, fetch, we, paused, if_seen;

        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.if_req_in = 1'b0; bus.if_addr_in = '0;
        bus.ls_req_in = 1'b0; bus.ls_we_in = 1'b0; bus.ls_size_in = '0;
        bus.ls_addr_in = '0; bus.ls_wdata_in = '0;
        preset[32'h100] = 8'h13; preset[32'h101] = 8'h05;
        preset[32'h102] = 8'hA0; preset[32'h103] = 8'h00;
        preset[32'h200] = 8'hEF; preset[32'h201] = 8'hBE;
        preset[32'h202] = 8'hAD; preset[32'h203] = 8'hDE;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check_eq("reset_mem_a", bus.mem_a, 32'h0);
        check_eq("reset_mem_wr", 32'(bus.mem_wr), 32'h0);
        check_eq("reset_mem_dout", 32'(bus.mem_dout), 32'h0);
        check_eq("reset_busy", 32'(busy_out), 32'h0);
        check_eq("reset_dones", {30'd0, bus.if_done_out, bus.ls_done_out}, 32'h0);
        check_eq("reset_if_data", bus.if_data_out, 32'h0);
        check_eq("reset_ls_rdata", bus.ls_rdata_out, 32'h0);

        // Word fetch: address sequence, 6-cycle latency, little-endian assembly.
        do_txn(1, 0, 2'd2, 32'h100, 32'h0, rd, lat, done);
        check_eq("fetch_done", 32'(done), 32'h1);
        check_eq("fetch_data", rd, 32'h00A00513);
        check_eq("fetch_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 4; i++) check_eq("fetch_addr_seq", a_log[i], 32'h100 + 32'(i));

        // Load wins over a simultaneous fetch; fetch follows after the turnaround.
        @(negedge clk_in);
        bus.ls_req_in = 1'b1; bus.ls_we_in = 1'b0; bus.ls_size_in = 2'd2;
        bus.ls_addr_in = 32'h200; bus.if_req_in = 1'b1; bus.if_addr_in = 32'h100;
        d_cyc = -1; if_seen = 0;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk_in); #1;
            if (bus.if_done_out) if_seen = 1;
            if (bus.ls_done_out) begin
                d_cyc = j;
                check_eq("prio_ls_rdata", bus.ls_rdata_out, 32'hDEADBEEF);
                break;
            end
        end
        bus.ls_req_in = 1'b0;
        check_eq("prio_ls_latency", 32'(d_cyc), 32'd6);
        check_eq("prio_no_early_fetch", 32'(if_seen), 32'h0);
        b_cyc = -1; f_cyc = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk_in); #1;
            if (busy_out && b_cyc < 0) b_cyc = k;
            if (bus.if_done_out) begin
                f_cyc = k;
                check_eq("prio_fetch_data", bus.if_data_out, 32'h00A00513);
                break;
            end
        end
        bus.if_req_in = 1'b0;
        check_eq("prio_fetch_busy", 32'(b_cyc), 32'd2);
        check_eq("prio_fetch_done", 32'(f_cyc), 32'd7);

        // IO byte store held off by a full UART buffer for three cycles.
        io0 = io_wr_cnt;
        iof_lo = 1; iof_hi = 3;
        do_txn(0, 1, 2'd0, 32'h00030000, 32'h41, rd, lat, done);
        model_store(32'h00030000, 1, 32'h41);
        wr_cnt = 0;
        foreach (wr_log[i]) if (wr_log[i]) wr_cnt++;
        check_eq("io_gated_wr", {29'd0, wr_log[0], wr_log[1], wr_log[2]}, 32'h0);
        check_eq("io_wr_count", 32'(wr_cnt), 32'd1);
        check_eq("io_wr_cycle", 32'(wr_log[3]), 32'h1);
        check_eq("io_wr_data", 32'(d_log[3]), 32'h41);
        check_eq("io_done_latency", 32'(lat), 32'd5);
        check_eq("io_bus_writes", 32'(io_wr_cnt - io0), 32'd1);
        check_eq("io_bus_byte", 32'(io_last), 32'h41);

        // Pause after byte 1 is captured: byte 2 address is re-driven on resume.
        pause_lo = 4; pause_hi = 7;
        do_txn(1, 0, 2'd2, 32'h100, 32'h0, rd, lat, done);
        check_eq("pause_redrive", a_log[7], 32'h102);
        check_eq("pause_data", rd, 32'h00A00513);
        check_eq("pause_latency", 32'(lat), 32'd11);

        // Flush aborts a fetch; a load is taken straight away.
        clr_at = 3;
        do_txn(1, 0, 2'd2, 32'h100, 32'h0, rd, lat, done);
        check_eq("clear_no_done", 32'(done), 32'h0);
        check_eq("clear_mem_a", a_log[3], 32'h0);
        check_eq("clear_mem_wr", 32'(wr_log[3]), 32'h0);
        do_txn(0, 0, 2'd2, 32'h200, 32'h0, rd, lat, done);
        check_eq("clear_then_load", rd, 32'hDEADBEEF);
        check_eq("clear_then_load_lat", 32'(lat), 32'd6);

        // Half store across the address wrap, then read it back.
        do_txn(0, 1, 2'd1, 32'hFFFFFFFF, 32'h1234BEEF, rd, lat, done);
        model_store(32'hFFFFFFFF, 2, 32'h1234BEEF);
        check_eq("wrap_addr0", a_log[0], 32'hFFFFFFFF);
        check_eq("wrap_addr1", a_log[1], 32'h00000000);
        check_eq("wrap_byte0", 32'(d_log[0]), 32'hEF);
        check_eq("wrap_byte1", 32'(d_log[1]), 32'hBE);
        check_eq("wrap_latency", 32'(lat), 32'd3);
        do_txn(0, 0, 2'd1, 32'hFFFFFFFF, 32'h0, rd, lat, done);
        check_eq("wrap_readback", rd, 32'h0000BEEF);

        // Randomized traffic against the word-level model.
        for (int t = 0; t < 60; t++) begin
            fetch = ($urandom_range(0, 2) == 0);
            we    = fetch ? 1'b0 : 1'($urandom_range(0, 1));
            size  = fetch ? 2'd2 : 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                                : 32'($urandom_range(0, 255));
            wd    = $urandom;
            n     = nbytes(size);
            paused = !we && ($urandom_range(0, 2) == 0);
            if (paused) begin
                pause_lo = $urandom_range(2, n + 1);
                pause_hi = pause_lo + $urandom_range(0, 2);
            end
            do_txn(fetch, we, size, addr, wd, rd, lat, done);
            check_eq("rand_done", 32'(done), 32'h1);
            if (we) model_store(addr, n, wd);
            else    check_eq("rand_rdata", rd, model_word(addr, n));
            if (!paused) check_eq("rand_latency", 32'(lat), 32'(we ? n + 1 : n + 2));
        end
        for (int i = 0; i < 8; i++) begin
            addr = 32'hFFFFFFF8 + 32'(i);
            check_eq("rand_ram_image", 32'(ram_rd(addr)), 32'(model_rd(addr)));
        end

        // Reset in the middle of a store: no done, bus released.
        @(negedge clk_in);
        bus.ls_req_in = 1'b1; bus.ls_we_in = 1'b1; bus.ls_size_in = 2'd2;
        bus.ls_addr_in = 32'h500; bus.ls_wdata_in = 32'hCAFEF00D;
        repeat (2) @(negedge clk_in);
        #1;
        check_eq("rst_mid_busy_before", 32'(busy_out), 32'h1);
        rst_in = 1'b1; bus.ls_req_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(busy_out), 32'h0);
        check_eq("rst_mid_mem_wr", 32'(bus.mem_wr), 32'h0);
        check_eq("rst_mid_no_done", 32'(bus.ls_done_out), 32'h0);
        repeat (3) begin
            @(negedge clk_in); #1;
            check_eq("rst_mid_quiet", {30'd0, busy_out, bus.ls_done_out}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
